// File: rtl/ascon_serial_host_if.sv
// Host request/response bundle for ascon_serial_host; share s of each field sits at [s*w +: w].
// One request accepted per req_valid&&req_ready; results qualified by the one-cycle done_o pulse.
interface ascon_serial_host_if #(
   parameter int k = 128,
   parameter int l = 80,
   parameter int y = 80
);
   logic             req_valid;
   logic             req_ready;
   logic             mode_i;
   logic [3*k-1:0]   key_i;
   logic [383:0]     nonce_i;
   logic [3*l-1:0]   ad_i;
   logic [3*y-1:0]   pt_i;
   logic [447:0]     rand_i;
   logic [y-1:0]     ct_o;
   logic [127:0]     tag_o;
   logic             done_o;
   logic             err_o;

   modport master (
      output req_valid, mode_i, key_i, nonce_i, ad_i, pt_i, rand_i,
      input  req_ready, ct_o, tag_o, done_o, err_o
   );

   modport slave (
      input  req_valid, mode_i, key_i, nonce_i, ad_i, pt_i, rand_i,
      output req_ready, ct_o, tag_o, done_o, err_o
   );
endinterface

// File: rtl/ascon_serial_host.sv
// Serialises masked key/nonce/AD/PT/randomness into a bit-serial Ascon core and captures tag/ct.
// ~132 cycles of load+shift, then core-dependent wait plus 128 capture cycles; req_ready only in IDLE.
module ascon_serial_host #(
   parameter int k       = 128,
   parameter int l       = 80,
   parameter int y       = 80,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               rst,
   ascon_serial_host_if.slave host,
   output logic               core_rst,
   output logic [2:0]         keyxSI,
   output logic [2:0]         noncexSI,
   output logic [2:0]         associated_dataxSI,
   output logic [2:0]         plain_textxSI,
   output logic [6:0]         rxSI,
   output logic               encryption_startxSI,
   output logic               decryption_startxSI,
   input  logic               cipher_textxSO,
   input  logic               tagxSO,
   input  logic               encryption_readyxSO,
   input  logic               decryption_readyxSO
);

   localparam int WDW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] RESET_CORE = 3'd1;
   localparam logic [2:0] SHIFT      = 3'd2;
   localparam logic [2:0] WAIT_READY = 3'd3;
   localparam logic [2:0] CAPTURE    = 3'd4;
   localparam logic [2:0] DONE       = 3'd5;

   logic [2:0]     state_q, state_d;
   logic [7:0]     c_q, c_d;
   logic [7:0]     m_q, m_d;
   logic [WDW-1:0] wd_q, wd_d;
   logic           mode_q, mode_d;
   logic           err_q, err_d;
   logic [y-1:0]   ct_q, ct_d;
   logic [127:0]   tag_q, tag_d;
   logic           load, shift;
   logic           in_shift, in_start;

   // Each share lives in its own shift register; its MSB is the serial bit for the current c.
   logic [2:0][k-1:0]   key_q;
   logic [2:0][127:0]   nonce_q;
   logic [2:0][l-1:0]   ad_q;
   logic [2:0][y-1:0]   pt_q;
   logic [6:0][63:0]    rnd_q;

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      m_d     = m_q;
      wd_d    = wd_q;
      mode_d  = mode_q;
      err_d   = err_q;
      ct_d    = ct_q;
      tag_d   = tag_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (host.req_valid) begin
               state_d = RESET_CORE;
               mode_d  = host.mode_i;
               err_d   = 1'b0;
               load    = 1'b1;
            end
         end
         RESET_CORE: begin
            state_d = SHIFT;
            c_d     = 8'd0;
         end
         SHIFT: begin
            shift = 1'b1;
            if (c_q == 8'd129) begin
               state_d = WAIT_READY;
               wd_d    = '0;
            end else begin
               c_d = c_q + 8'd1;
            end
         end
         WAIT_READY: begin
            if (!mode_q && encryption_readyxSO) begin
               state_d = CAPTURE;
               m_d     = 8'd0;
            end else if (mode_q && decryption_readyxSO) begin
               state_d = DONE;
            end else if (wd_q == WDW'(TIMEOUT - 1)) begin
               state_d = DONE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         CAPTURE: begin
            for (int i = 0; i < 128; i++) begin
               if (m_q == 8'(i)) tag_d[i] = tagxSO;
            end
            for (int i = 0; i < y; i++) begin
               if (m_q == 8'(i)) ct_d[i] = cipher_textxSO;
            end
            if (m_q == 8'd127) state_d = DONE;
            else               m_d     = m_q + 8'd1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         m_q     <= '0;
         wd_q    <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         ct_q    <= '0;
         tag_q   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         m_q     <= m_d;
         wd_q    <= wd_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         ct_q    <= ct_d;
         tag_q   <= tag_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         key_q   <= host.key_i;
         nonce_q <= host.nonce_i;
         ad_q    <= host.ad_i;
         pt_q    <= host.pt_i;
         rnd_q   <= host.rand_i;
      end else if (shift) begin
         for (int s = 0; s < 3; s++) begin
            key_q[s]   <= {key_q[s][k-2:0], 1'b0};
            nonce_q[s] <= {nonce_q[s][126:0], 1'b0};
            ad_q[s]    <= {ad_q[s][l-2:0], 1'b0};
            pt_q[s]    <= {pt_q[s][y-2:0], 1'b0};
         end
         for (int w = 0; w < 7; w++) begin
            rnd_q[w] <= {rnd_q[w][62:0], 1'b0};
         end
      end
   end

   assign in_shift = (state_q == SHIFT) && !rst;
   assign in_start = ((state_q == WAIT_READY) || (state_q == CAPTURE)) && !rst;

   always_comb begin
      keyxSI             = '0;
      noncexSI           = '0;
      associated_dataxSI = '0;
      plain_textxSI      = '0;
      rxSI               = '0;
      for (int s = 0; s < 3; s++) begin
         keyxSI[s]             = in_shift & key_q[s][k-1];
         noncexSI[s]           = in_shift & nonce_q[s][127];
         associated_dataxSI[s] = in_shift & ad_q[s][l-1];
         plain_textxSI[s]      = in_shift & pt_q[s][y-1];
      end
      for (int w = 0; w < 7; w++) begin
         rxSI[w] = in_shift & rnd_q[w][63];
      end
   end

   assign core_rst            = rst || (state_q == RESET_CORE);
   assign encryption_startxSI = in_start & ~mode_q;
   assign decryption_startxSI = in_start & mode_q;

   assign host.req_ready = (state_q == IDLE);
   assign host.done_o    = (state_q == DONE) && !rst;
   assign host.err_o     = err_q;
   assign host.ct_o      = ct_q;
   assign host.tag_o     = tag_q;

endmodule
